// File: rtl/axis_result_packer_if.sv
// Stream bundle between the overlay result port, the packer and the DMA S2MM side.
// The master modport is the packer's view: it drives the wide DMA beat and the
// ready back to the overlay. The slave modport is the surrounding environment's view.
interface axis_result_packer_if #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned RATIO = 2
);
  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned KEEP_W = OUT_W / 8;

  logic [IN_W-1:0]   s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/axis_result_packer.sv
// Packs narrow overlay result words into wide DMA beats (first word in the LSBs),
// builds TKEEP for short tails, bounds packet length by forcing TLAST, and counts
// emitted packets.
module axis_result_packer #(
  parameter int unsigned IN_W          = 32,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned MAX_OUT_BEATS = 256
) (
  input  logic                 clk,
  input  logic                 aresetn,
  axis_result_packer_if.master axis,
  output logic [31:0]          pkt_count,
  output logic                 forced_last
);
  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned KEEP_W = OUT_W / 8;
  localparam int unsigned LANE_K = IN_W / 8;
  localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned CNT_W  = (MAX_OUT_BEATS > 1) ? $clog2(MAX_OUT_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_OUT_BEATS > 0) ? MAX_OUT_BEATS - 1 : 0);

  // ACC_HOLD: accumulator holds a completed beat waiting for the output register.
  typedef enum logic {ACC_FILL, ACC_HOLD} acc_state_t;
  acc_state_t state, state_next;

  logic [OUT_W-1:0]  acc_data, merged_data, out_data;
  logic [KEEP_W-1:0] acc_keep, merged_keep, out_keep;
  logic [IDX_W-1:0]  idx;
  logic              acc_last, out_last, out_valid;
  logic [CNT_W-1:0]  beat_cnt;
  logic              accept, drain, out_free, complete;
  logic              move_pending, move_new, force_hit;

  assign axis.s_axis_tready = aresetn & (state == ACC_FILL);
  assign accept       = axis.s_axis_tvalid & axis.s_axis_tready;
  assign drain        = out_valid & axis.m_axis_tready;
  assign out_free     = ~out_valid | drain;
  assign complete     = accept & (axis.s_axis_tlast | (idx == LAST_IDX));
  assign move_pending = (state == ACC_HOLD) & out_free;
  assign move_new     = complete & out_free;
  assign force_hit    = (MAX_OUT_BEATS != 0) && (beat_cnt == LAST_CNT);

  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tkeep  = out_keep;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tlast  = out_last | (out_valid & force_hit);

  // Accumulator contents with the incoming word written into its lane.
  always_comb begin
    merged_data = acc_data;
    merged_keep = acc_keep;
    merged_data[idx*IN_W +: IN_W]     = axis.s_axis_tdata;
    merged_keep[idx*LANE_K +: LANE_K] = '1;
  end

  // Next accumulator state: hold a completed beat while the output register is busy.
  always_comb begin
    state_next = state;
    case (state)
      ACC_FILL: if (complete && !out_free) state_next = ACC_HOLD;
      ACC_HOLD: if (out_free) state_next = ACC_FILL;
      default:  state_next = ACC_FILL;
    endcase
  end

  // Accumulator state register.
  always_ff @(posedge clk) begin
    if (!aresetn) state <= ACC_FILL;
    else          state <= state_next;
  end

  // Accumulator lanes: fill word by word, clear once the beat has left for the output.
  always_ff @(posedge clk) begin
    if (!aresetn || move_pending || move_new) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      idx      <= '0;
    end else if (accept) begin
      acc_data <= merged_data;
      acc_keep <= merged_keep;
      if (complete) begin
        acc_last <= axis.s_axis_tlast;
        idx      <= '0;
      end else begin
        idx      <= idx + IDX_W'(1);
      end
    end
  end

  // Output register: a pending beat takes priority since no word is accepted while one is held.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (move_pending) begin
      out_data  <= acc_data;
      out_keep  <= acc_keep;
      out_last  <= acc_last;
      out_valid <= 1'b1;
    end else if (move_new) begin
      out_data  <= merged_data;
      out_keep  <= merged_keep;
      out_last  <= axis.s_axis_tlast;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Packet bookkeeping on each output handshake.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      beat_cnt    <= '0;
      pkt_count   <= '0;
      forced_last <= 1'b0;
    end else if (drain) begin
      if (axis.m_axis_tlast) begin
        beat_cnt  <= '0;
        pkt_count <= pkt_count + 32'd1;
      end else begin
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end
      if (force_hit && !out_last) forced_last <= 1'b1;
    end
  end
endmodule
